// File: rtl/svm_vote_smoother.sv
// svm_vote_smoother: majority vote over the last WINDOW SVM valence/arousal
// decisions. Each vote result is queued in a small result FIFO.
// Stage 1 updates the window and counts. Stage 2 computes the vote and pushes it.
module svm_vote_smoother #(
  parameter int unsigned WINDOW     = 8,
  parameter int unsigned LOG_WINDOW = $clog2(WINDOW + 1),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valence,
  input  logic                  arousal,
  input  logic                  din_valid,
  input  logic                  clr,
  output logic [1:0]            quadrant,
  output logic [LOG_WINDOW-1:0] fill,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow
);

  localparam int unsigned WPTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = FPTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    VOTE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   push_c;

  // Window storage and running state.
  logic [WINDOW-1:0]     win_v;
  logic [WINDOW-1:0]     win_a;
  logic [WPTR_W-1:0]     wptr;
  logic [LOG_WINDOW-1:0] v_cnt;
  logic [LOG_WINDOW-1:0] a_cnt;
  logic                  last_v;
  logic                  last_a;

  logic                  win_full_c;
  logic                  old_v_c;
  logic                  old_a_c;
  logic [LOG_WINDOW-1:0] v_cnt_nxt_c;
  logic [LOG_WINDOW-1:0] a_cnt_nxt_c;
  logic [LOG_WINDOW-1:0] fill_nxt_c;
  logic [WPTR_W-1:0]     wptr_nxt_c;

  // Vote evaluation.
  logic [LOG_WINDOW:0]   v_dbl_c;
  logic [LOG_WINDOW:0]   a_dbl_c;
  logic [LOG_WINDOW:0]   fill_ext_c;
  logic                  v_vote_c;
  logic                  a_vote_c;
  logic [1:0]            push_data_c;

  // Result FIFO.
  logic [1:0]            mem [FIFO_DEPTH];
  logic [FPTR_W-1:0]     rd_ptr;
  logic [FPTR_W-1:0]     wr_ptr;
  logic [FCNT_W-1:0]     f_cnt;

  logic                  pop_c;
  logic                  fifo_full_c;
  logic                  push_ok_c;
  logic                  drop_c;
  logic [FCNT_W-1:0]     f_cnt_nxt_c;
  logic [FPTR_W-1:0]     rd_plus1_c;
  logic [1:0]            head_nxt_c;

  // Sample sequencing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a vote is pushed on every cycle spent in VOTE.
  always_comb begin
    state_nxt = state;
    push_c    = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid) begin
          state_nxt = VOTE;
        end
      end
      VOTE: begin
        push_c    = 1'b1;
        state_nxt = din_valid ? VOTE : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clr) begin
      state_nxt = IDLE;
      push_c    = 1'b0;
    end
  end

  // Next window counts. Once the window is full, the entry under wptr is evicted.
  always_comb begin
    win_full_c  = (fill == LOG_WINDOW'(WINDOW));
    old_v_c     = win_full_c ? win_v[wptr] : 1'b0;
    old_a_c     = win_full_c ? win_a[wptr] : 1'b0;
    v_cnt_nxt_c = v_cnt + LOG_WINDOW'(valence) - LOG_WINDOW'(old_v_c);
    a_cnt_nxt_c = a_cnt + LOG_WINDOW'(arousal) - LOG_WINDOW'(old_a_c);
    fill_nxt_c  = win_full_c ? fill : fill + LOG_WINDOW'(1);
    wptr_nxt_c  = (wptr == WPTR_W'(WINDOW - 1)) ? '0 : wptr + WPTR_W'(1);
  end

  // Stage 1: window entry, pointer, fill and counts update on an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_v  <= '0;
      win_a  <= '0;
      wptr   <= '0;
      fill   <= '0;
      v_cnt  <= '0;
      a_cnt  <= '0;
      last_v <= 1'b0;
      last_a <= 1'b0;
    end else if (clr) begin
      win_v  <= '0;
      win_a  <= '0;
      wptr   <= '0;
      fill   <= '0;
      v_cnt  <= '0;
      a_cnt  <= '0;
      last_v <= 1'b0;
      last_a <= 1'b0;
    end else if (din_valid) begin
      win_v[wptr] <= valence;
      win_a[wptr] <= arousal;
      wptr        <= wptr_nxt_c;
      fill        <= fill_nxt_c;
      v_cnt       <= v_cnt_nxt_c;
      a_cnt       <= a_cnt_nxt_c;
      last_v      <= valence;
      last_a      <= arousal;
    end
  end

  // Majority vote. A tie follows the most recent sample of that class.
  always_comb begin
    v_dbl_c    = {v_cnt, 1'b0};
    a_dbl_c    = {a_cnt, 1'b0};
    fill_ext_c = {1'b0, fill};
    if (v_dbl_c > fill_ext_c) begin
      v_vote_c = 1'b1;
    end else if (v_dbl_c < fill_ext_c) begin
      v_vote_c = 1'b0;
    end else begin
      v_vote_c = last_v;
    end
    if (a_dbl_c > fill_ext_c) begin
      a_vote_c = 1'b1;
    end else if (a_dbl_c < fill_ext_c) begin
      a_vote_c = 1'b0;
    end else begin
      a_vote_c = last_a;
    end
    push_data_c = {v_vote_c, a_vote_c};
  end

  // FIFO control. A pop frees a full FIFO for the push in the same cycle.
  // The registered head is computed ahead of time.
  always_comb begin
    pop_c       = dout_valid & dout_ready;
    fifo_full_c = (f_cnt == FCNT_W'(FIFO_DEPTH));
    push_ok_c   = push_c & (~fifo_full_c | pop_c);
    drop_c      = push_c & fifo_full_c & ~pop_c;
    f_cnt_nxt_c = f_cnt + FCNT_W'(push_ok_c) - FCNT_W'(pop_c);
    rd_plus1_c  = rd_ptr + FPTR_W'(1);
    head_nxt_c  = 2'b00;
    if (f_cnt_nxt_c != '0) begin
      if (pop_c) begin
        head_nxt_c = (f_cnt > FCNT_W'(1)) ? mem[rd_plus1_c] : push_data_c;
      end else if (f_cnt == '0) begin
        head_nxt_c = push_data_c;
      end else begin
        head_nxt_c = mem[rd_ptr];
      end
    end
  end

  // Stage 2: result FIFO storage, pointers, registered head and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      f_cnt      <= '0;
      dout_valid <= 1'b0;
      quadrant   <= 2'b00;
      overflow   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= 2'b00;
      end
    end else if (clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      f_cnt      <= '0;
      dout_valid <= 1'b0;
      quadrant   <= 2'b00;
      overflow   <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= push_data_c;
        wr_ptr      <= wr_ptr + FPTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_plus1_c;
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
      f_cnt      <= f_cnt_nxt_c;
      dout_valid <= (f_cnt_nxt_c != '0);
      quadrant   <= head_nxt_c;
    end
  end

endmodule

// File: tb/tb_svm_vote_smoother.sv
// Directed bench for svm_vote_smoother with WINDOW=4 and FIFO_DEPTH=4.
module tb_svm_vote_smoother;

  logic       clk = 1'b0;
  logic       rst;
  logic       valence;
  logic       arousal;
  logic       din_valid;
  logic       clr;
  logic [1:0] quadrant;
  logic [2:0] fill;
  logic       dout_valid;
  logic       dout_ready;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [1:0] got [$];

  svm_vote_smoother #(
    .WINDOW     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valence    (valence),
    .arousal    (arousal),
    .din_valid  (din_valid),
    .clr        (clr),
    .quadrant   (quadrant),
    .fill       (fill),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge. The entry popped at that edge is logged just before it.
  task automatic tick();
    if (dout_valid && dout_ready) got.push_back(quadrant);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; valence = 1'b0; arousal = 1'b0; din_valid = 1'b0;
    clr = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (quadrant !== 2'b00) begin errors++; $display("FAIL rst_quadrant: got %b want 00", quadrant); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_fill: got %0d want 0", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    dout_ready = 1'b1;
    valence = 1'b1; arousal = 1'b0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", dout_valid); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL lat_fill: got %0d want 1", fill); end
    tick();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", dout_valid); end
    checks++; if (quadrant !== 2'b10) begin errors++; $display("FAIL lat_quadrant: got %b want 10", quadrant); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lat_popped: got %b want 0", dout_valid); end
    do_clr();
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_fill: got %0d want 0", fill); end
  endtask

  task automatic test_tie();
    dout_ready = 1'b1;
    valence = 1'b1; arousal = 1'b1; din_valid = 1'b1;
    tick();
    valence = 1'b0; arousal = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) tick();
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL tie_count: got %0d want 2", got.size()); end
    if (got.size() >= 2) begin
      checks++; if (got[0] !== 2'b11) begin errors++; $display("FAIL tie_first: got %b want 11", got[0]); end
      checks++; if (got[1] !== 2'b01) begin errors++; $display("FAIL tie_second: got %b want 01", got[1]); end
    end
    do_clr();
  endtask

  task automatic test_eviction();
    logic [1:0] exp_q [7];
    exp_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    dout_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      valence = (i < 4); arousal = (i >= 4); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    repeat (4) tick();
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL evict_fill: got %0d want 4", fill); end
    checks++; if (got.size() !== 7) begin errors++; $display("FAIL evict_count: got %0d want 7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL evict_result%0d: got %b want %b", i, got[i], exp_q[i]); end
      end
    end
    do_clr();
  endtask

  task automatic test_overflow();
    logic [1:0] sv_q [6];
    logic [1:0] exp_q [4];
    sv_q  = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
    exp_q = '{2'b10, 2'b01, 2'b01, 2'b11};
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {valence, arousal} = sv_q[i]; din_valid = 1'b1;
      tick();
      if (i == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      if (i == 5) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      end
    end
    din_valid = 1'b0;
    tick();
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill: got %0d want 4", fill); end
    dout_ready = 1'b1;
    repeat (6) tick();
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_order%0d: got %b want %b", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    do_clr();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sv_q [5];
    logic [1:0] exp_q [5];
    sv_q  = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b01};
    exp_q = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {valence, arousal} = sv_q[i]; din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_push_ovf: got %b want 0", overflow); end
    repeat (6) tick();
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL full_pop_push_count: got %0d want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_pop_push%0d: got %b want %b", i, got[i], exp_q[i]); end
      end
    end
    do_clr();
  endtask

  task automatic test_clear();
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valence = 1'b1; arousal = 1'b0; din_valid = 1'b1;
      tick();
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %b want 1", overflow); end
    clr = 1'b1;
    tick();
    clr = 1'b0; din_valid = 1'b0;
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_din_fill: got %0d want 0", fill); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL clr_din_valid: got %b want 0", dout_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_din_ovf: got %b want 0", overflow); end
    repeat (2) tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL clr_no_stale: got %b want 0", dout_valid); end
    got.delete();
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valence = 1'b1; arousal = 1'b1; din_valid = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1; din_valid = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", dout_valid); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rstmid_fill: got %0d want 0", fill); end
    checks++; if (quadrant !== 2'b00) begin errors++; $display("FAIL rstmid_quadrant: got %b want 00", quadrant); end
    #1;
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b want 0", dout_valid); end
    dout_ready = 1'b1;
    valence = 1'b0; arousal = 1'b1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_first_early: got %b want 0", dout_valid); end
    tick();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rstmid_first_valid: got %b want 1", dout_valid); end
    checks++; if (quadrant !== 2'b01) begin errors++; $display("FAIL rstmid_first_quadrant: got %b want 01", quadrant); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL rstmid_first_fill: got %0d want 1", fill); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tie();
    test_eviction();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
